// File: rtl/cordic_atan2_seq.sv
// Sequential vectoring-mode CORDIC: atan2(iny, inx) in degrees, one micro-rotation per clock.
// Optional macro CORDIC_MAG_OUT_EN adds the gain-compensated magnitude output 'mag'.
module cordic_atan2_seq #(
    parameter int DW   = 32,
    parameter int AW   = 32,
    parameter int FRAC = 16,
    parameter int ITER = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [DW-1:0] inx,
    input  logic signed [DW-1:0] iny,
    output logic                 busy,
    output logic                 done,
    output logic signed [AW-1:0] angle,
    output logic                 zero_in
`ifdef CORDIC_MAG_OUT_EN
    ,
    output logic [DW:0]          mag
`endif
);

    // x/y keep G guard bits below the operand LSB so truncation in the
    // shifted adds stays far below one output LSB, even for tiny operands.
    localparam int G    = DW;
    localparam int IW   = DW + 2 + G;
    localparam int ZW   = (AW > FRAC + 11) ? AW : FRAC + 11;
    localparam int SH_L = (FRAC >= 16) ? FRAC - 16 : 0;
    localparam int SH_R = (FRAC < 16) ? 16 - FRAC : 0;
    localparam longint RND = (longint'(1) <<< SH_R) >>> 1;
    localparam logic signed [ZW-1:0] Z180 = ZW'(longint'(180) <<< FRAC);
    localparam logic [4:0] LAST = 5'(ITER - 1);

    generate
        if (ITER < 1 || ITER > 32) begin : g_bad_iter
            $error("cordic_atan2_seq: ITER must be in 1..32");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_ITER,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic signed [IW-1:0] x_q, x_d;
    logic signed [IW-1:0] y_q, y_d;
    logic signed [ZW-1:0] z_q, z_d;
    logic [4:0]           cnt_q, cnt_d;
    logic                 zr_q, zr_d;
    logic signed [AW-1:0] angle_q, angle_d;
    logic                 zero_q, zero_d;
    logic                 done_q, done_d;
`ifdef CORDIC_MAG_OUT_EN
    localparam int PW = IW + 16;
    localparam logic signed [15:0] MAGK = 16'sd19898;
    logic [DW:0]          mag_q, mag_d;
`endif

    logic signed [IW-1:0] xs, ys;
    logic signed [ZW-1:0] at;

    // atan(2^-k) in degrees; base values carry 16 fractional bits and are
    // rescaled (rounded when narrowing) to FRAC.
    function automatic logic signed [ZW-1:0] atan_lut(input logic [4:0] k);
        longint t;
        unique case (k)
            5'd0:    t = 64'sd2949120;
            5'd1:    t = 64'sd1740967;
            5'd2:    t = 64'sd919879;
            5'd3:    t = 64'sd466945;
            5'd4:    t = 64'sd234379;
            5'd5:    t = 64'sd117304;
            5'd6:    t = 64'sd58666;
            5'd7:    t = 64'sd29335;
            5'd8:    t = 64'sd14668;
            5'd9:    t = 64'sd7334;
            5'd10:   t = 64'sd3667;
            5'd11:   t = 64'sd1833;
            5'd12:   t = 64'sd917;
            5'd13:   t = 64'sd458;
            5'd14:   t = 64'sd229;
            5'd15:   t = 64'sd115;
            5'd16:   t = 64'sd57;
            5'd17:   t = 64'sd29;
            5'd18:   t = 64'sd14;
            5'd19:   t = 64'sd7;
            5'd20:   t = 64'sd4;
            5'd21:   t = 64'sd2;
            5'd22:   t = 64'sd1;
            default: t = 64'sd0;
        endcase
        t = ((t <<< SH_L) + RND) >>> SH_R;
        return ZW'(t);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: IDLE -> PRE -> ITER x ITER -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_PRE;
            S_PRE:   state_d = S_ITER;
            S_ITER:  if (cnt_q == LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next state: capture, quadrant fold, micro-rotation, result latch
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        zr_d    = zr_q;
        angle_d = angle_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
`ifdef CORDIC_MAG_OUT_EN
        mag_d   = mag_q;
`endif
        xs = x_q >>> cnt_q;
        ys = y_q >>> cnt_q;
        at = atan_lut(cnt_q);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d  = {{2{inx[DW-1]}}, inx, {G{1'b0}}};
                    y_d  = {{2{iny[DW-1]}}, iny, {G{1'b0}}};
                    z_d  = '0;
                    zr_d = (inx == '0) && (iny == '0);
                end
            end
            S_PRE: begin
                cnt_d = '0;
                if (x_q[IW-1]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = y_q[IW-1] ? -Z180 : Z180;
                end else begin
                    z_d = '0;
                end
            end
            S_ITER: begin
                if (!y_q[IW-1]) begin
                    x_d = x_q + ys;
                    y_d = y_q - xs;
                    z_d = z_q + at;
                end else begin
                    x_d = x_q - ys;
                    y_d = y_q + xs;
                    z_d = z_q - at;
                end
                cnt_d = cnt_q + 5'd1;
            end
            S_DONE: begin
                angle_d = zr_q ? '0 : z_q[AW-1:0];
                zero_d  = zr_q;
                done_d  = 1'b1;
`ifdef CORDIC_MAG_OUT_EN
                mag_d = (DW+1)'((PW'(x_q >>> G) * PW'(MAGK)) >>> 15);
`endif
            end
            default: ;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            zr_q    <= 1'b0;
            angle_q <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CORDIC_MAG_OUT_EN
            mag_q   <= '0;
`endif
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            zr_q    <= zr_d;
            angle_q <= angle_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
`ifdef CORDIC_MAG_OUT_EN
            mag_q   <= mag_d;
`endif
        end
    end

    // Outputs: busy spans the whole operation including the done cycle
    always_comb begin
        busy    = (state_q != S_IDLE) || done_q;
        done    = done_q;
        angle   = angle_q;
        zero_in = zero_q;
`ifdef CORDIC_MAG_OUT_EN
        mag     = mag_q;
`endif
    end

endmodule

// File: tb/tb_cordic_atan2_seq.sv
// Scoreboard bench for cordic_atan2_seq: real-arithmetic atan2 reference,
// timing checks on busy/done, back-to-back starts and mid-operation reset.
module tb_cordic_atan2_seq;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int FRAC = 16;
    localparam int ITER = 24;
    localparam int P    = ITER + 3;
    localparam real PI  = 3.14159265358979323846;
    localparam real TOL = 16.0;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic signed [DW-1:0] inx   = '0;
    logic signed [DW-1:0] iny   = '0;
    logic                 busy;
    logic                 done;
    logic signed [AW-1:0] angle;
    logic                 zero_in;
`ifdef CORDIC_MAG_OUT_EN
    logic [DW:0]          mag;
`endif

    typedef struct {
        real ang;
        bit  zr;
        real mg;
        int  x;
        int  y;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    real  gain     = 1.0;

    always #5 clk = ~clk;

    cordic_atan2_seq #(
        .DW(DW), .AW(AW), .FRAC(FRAC), .ITER(ITER)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .inx(inx),
        .iny(iny),
        .busy(busy),
        .done(done),
        .angle(angle),
        .zero_in(zero_in)
`ifdef CORDIC_MAG_OUT_EN
        ,
        .mag(mag)
`endif
    );

    task automatic chk(input string nm, input bit ok,
                       input longint got, input longint want);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    function automatic exp_t model(input int x, input int y);
        exp_t e;
        real  r;
        e.x = x;
        e.y = y;
        if (x == 0 && y == 0) begin
            e.ang = 0.0;
            e.zr  = 1'b1;
        end else begin
            e.ang = $atan2(real'(y), real'(x)) * 180.0 / PI * (2.0 ** FRAC);
            e.zr  = 1'b0;
        end
        r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        e.mg = $floor(r * gain * 19898.0 / 32768.0);
        return e;
    endfunction

    function automatic int rnd_op();
        int v;
        v = int'($urandom()) >>> $urandom_range(0, 22);
        if (v > -256 && v < 256) v = (v < 0) ? v - 256 : v + 256;
        return v;
    endfunction

    // Monitor: every done pops one expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1'b0, 1, 0);
            end else begin
                exp_t e;
                real  d;
                e = sbq.pop_front();
                d = real'(angle) - e.ang;
                chk($sformatf("angle(%0d,%0d)", e.x, e.y),
                    (d <= TOL) && (d >= -TOL),
                    longint'(angle), longint'(e.ang));
                chk($sformatf("zero_in(%0d,%0d)", e.x, e.y),
                    zero_in == e.zr, longint'(zero_in), longint'(e.zr));
`ifdef CORDIC_MAG_OUT_EN
                d = real'(mag) - e.mg;
                chk($sformatf("mag(%0d,%0d)", e.x, e.y),
                    (d <= 4.0) && (d >= -4.0),
                    longint'(mag), longint'(e.mg));
`endif
            end
        end
    end

    task automatic chk_cleared(input string pfx);
        chk({pfx, "_busy"}, busy == 1'b0, longint'(busy), 0);
        chk({pfx, "_done"}, done == 1'b0, longint'(done), 0);
        chk({pfx, "_angle"}, angle == '0, longint'(angle), 0);
        chk({pfx, "_zero_in"}, zero_in == 1'b0, longint'(zero_in), 0);
`ifdef CORDIC_MAG_OUT_EN
        chk({pfx, "_mag"}, mag == '0, longint'(mag), 0);
`endif
    endtask

    task automatic run_op(input int x, input int y);
        int lat;
        int bc;
        int dc;
        @(negedge clk);
        inx   = x;
        iny   = y;
        start = 1'b1;
        sbq.push_back(model(x, y));
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        bc  = 0;
        dc  = 0;
        for (int k = 1; k <= ITER + 8; k++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                dc++;
                if (lat == 0) lat = k;
            end
        end
        chk("latency", lat == ITER + 3, lat, ITER + 3);
        chk("busy_cycles", bc == ITER + 3, bc, ITER + 3);
        chk("done_pulses", dc == 1, dc, 1);
    endtask

    initial begin
        int dc;
        for (int i = 0; i < ITER; i++) gain = gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_cleared("reset");
        rst_n = 1'b1;

        run_op(1000, 1000);
        run_op(-1000, 0);
        run_op(0, -5000);
        run_op(-3000, -3000);
        run_op(int'(32'h8000_0000), int'(32'h8000_0000));
        run_op(0, 0);
        run_op(5, 0);
        run_op(3000, 4000);

        // start held high with operands changing every cycle
        dc = 0;
        for (int c = 0; c <= 2 * P; c++) begin
            @(negedge clk);
            if (done) dc++;
            inx   = rnd_op();
            iny   = rnd_op();
            start = 1'b1;
            if (c % P == 0) sbq.push_back(model(int'(inx), int'(iny)));
        end
        @(negedge clk);
        if (done) dc++;
        start = 1'b0;
        for (int k = 0; k < ITER + 8; k++) begin
            @(negedge clk);
            if (done) dc++;
        end
        chk("tput_dones", dc == 3, dc, 3);

        // reset pulse in the middle of the rotations
        @(negedge clk);
        inx   = 7000;
        iny   = -2000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_cleared("abort");
        rst_n = 1'b1;
        dc = 0;
        for (int k = 0; k < ITER + 6; k++) begin
            @(negedge clk);
            if (done) dc++;
        end
        chk("abort_no_done", dc == 0, dc, 0);
        run_op(7000, -2000);

        for (int n = 0; n < 16; n++) begin
            int rx;
            int ry;
            rx = rnd_op();
            ry = rnd_op();
            if (n == 3) rx = 0;
            if (n == 7) ry = 0;
            run_op(rx, ry);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sbq.size() == 0, sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
